dprob_scan_ctrl: RTL

// - Sequencer for the class-probability pipeline: walks every (set, addr) anchor record in the prob buffer.
// - Streams each record, the scale value and its tags into the pipeline one per cycle, marking the final one last.
// - Waits for the pipeline's last result and latches the winning addr/set as the frame's best detection.
// - Sits between the bounding-box prob buffer (BRAM) and the dprob datapath; started once per frame by the layer FSM.

---
 rtl/dprob_scan_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dprob_scan_ctrl.sv
// Prob-buffer scan sequencer: streams every (set, addr) record into the dprob pipeline
// and latches the frame winner. Optional WAIT watchdog enabled by DPROB_WDOG_EN.
module dprob_scan_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int SET_W   = 3,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 63
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       last_addr,
  input  logic [SET_W-1:0]        last_set,
  input  logic [DATA_W-1:0]       scale_in,
  output logic                    mem_rd_en,
  output logic [SET_W+ADDR_W-1:0] mem_rd_addr,
  input  logic [3*DATA_W-1:0]     mem_rd_data,
  output logic                    pipe_valid,
  output logic                    pipe_last,
  output logic [ADDR_W-1:0]       pipe_addr,
  output logic [SET_W-1:0]        pipe_set,
  output logic [DATA_W-1:0]       pipe_max,
  output logic [DATA_W-1:0]       pipe_min,
  output logic [DATA_W-1:0]       pipe_sum,
  output logic [DATA_W-1:0]       pipe_scale,
  input  logic                    res_valid,
  input  logic                    res_last,
  input  logic [ADDR_W-1:0]       res_addr,
  input  logic [SET_W-1:0]        res_set,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       best_addr,
  output logic [SET_W-1:0]        best_set,
  output logic                    error
);

  if (MEM_LAT < 1 || MEM_LAT > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $fatal(1, "dprob_scan_ctrl: MEM_LAT or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT} state_t;

  localparam int TAG_W = ADDR_W + SET_W + 2;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, last_addr_q;
  logic [SET_W-1:0]    set_q, last_set_q;
  logic [DATA_W-1:0]   scale_q;
  logic [TAG_W-1:0]    tag_dly_q [MEM_LAT];
  logic [TAG_W-1:0]    tag_in;
  logic                issue, final_rd, res_done, wdog_expire;

  assign issue    = (state_q == ISSUE);
  assign final_rd = issue && (addr_q == last_addr_q) && (set_q == last_set_q);
  assign res_done = (state_q == WAIT) && res_valid && res_last;
  assign tag_in   = issue ? {final_rd, 1'b1, set_q, addr_q} : '0;

  assign {pipe_last, pipe_valid, pipe_set, pipe_addr} = tag_dly_q[MEM_LAT-1];
  assign pipe_sum    = pipe_valid ? mem_rd_data[3*DATA_W-1:2*DATA_W] : '0;
  assign pipe_min    = pipe_valid ? mem_rd_data[2*DATA_W-1:DATA_W]   : '0;
  assign pipe_max    = pipe_valid ? mem_rd_data[DATA_W-1:0]          : '0;
  assign pipe_scale  = scale_q;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? {set_q, addr_q} : '0;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // DRAIN ends once the final record's tag has reached the output of the delay line.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: if (final_rd) state_d = DRAIN;
      DRAIN: if (pipe_last) state_d = WAIT;
      WAIT:  if (res_done || wdog_expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      set_q       <= '0;
      last_addr_q <= '0;
      last_set_q  <= '0;
      scale_q     <= '0;
      best_addr   <= '0;
      best_set    <= '0;
      done        <= 1'b0;
      for (int unsigned i = 0; i < MEM_LAT; i++) tag_dly_q[i] <= '0;
    end else begin
      done         <= res_done || wdog_expire;
      tag_dly_q[0] <= tag_in;
      for (int unsigned i = 1; i < MEM_LAT; i++) tag_dly_q[i] <= tag_dly_q[i-1];
      if (state_q == IDLE && start) begin
        last_addr_q <= last_addr;
        last_set_q  <= last_set;
        scale_q     <= scale_in;
        addr_q      <= '0;
        set_q       <= '0;
      end else if (issue) begin
        if (addr_q == last_addr_q) begin
          addr_q <= '0;
          set_q  <= (set_q == last_set_q) ? '0 : set_q + 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
      if (res_done) begin
        best_addr <= res_addr;
        best_set  <= res_set;
      end
    end
  end

`ifdef DPROB_WDOG_EN
  logic [7:0] wdog_q;
  logic       error_q;

  // A same-cycle result beats the timeout so a valid winner is never discarded.
  assign wdog_expire = (state_q == WAIT) && !res_done && (wdog_q == 8'(TIMEOUT - 1));
  assign error       = error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q <= (state_q == WAIT) ? wdog_q + 8'd1 : '0;
      if (state_q == IDLE && start) error_q <= 1'b0;
      else if (wdog_expire)         error_q <= 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign error       = 1'b0;
`endif

endmodule
